// File: rtl/digit_serial_adder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : digit_serial_adder_pkg                                       |
// | Description : Shared types and helper functions for the digit-serial       |
// |               adder/subtractor (FSM state type, counter width, saturation  |
// |               constants).                                                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package digit_serial_adder_pkg;

  // Controller states
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Digit counter width: at least one bit even when there is only one digit
  function automatic int cnt_width(input int ndig);
    return (ndig <= 1) ? 1 : $clog2(ndig);
  endfunction

  // Largest positive two's-complement value of a w-bit word (0111...1)
  function automatic logic [63:0] sat_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  // Most negative two's-complement value of a w-bit word (1000...0)
  function automatic logic [63:0] sat_min(input int w);
    return 64'd1 << (w - 1);
  endfunction

endpackage : digit_serial_adder_pkg
`default_nettype wire

// File: rtl/ripple_digit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ripple_digit                                                 |
// | Description : DIGIT-bit combinational ripple-carry slice. Also exposes the |
// |               carry into the slice MSB so the caller can detect signed     |
// |               overflow when this slice holds the word MSB.                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module ripple_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             c_msb_in
);

  // w_c[i] is the carry into bit i; w_c[DIGIT] is the slice carry out
  logic [DIGIT:0] w_c;

  assign w_c[0] = ci;

  // One full adder per bit of the digit
  generate
    for (genvar i = 0; i < DIGIT; i++) begin : g_bit
      assign s[i]     = a[i] ^ b[i] ^ w_c[i];
      assign w_c[i+1] = (a[i] & b[i]) | (a[i] & w_c[i]) | (b[i] & w_c[i]);
    end
  endgenerate

  assign co       = w_c[DIGIT];
  assign c_msb_in = w_c[DIGIT-1];

endmodule : ripple_digit
`default_nettype wire

// File: rtl/digit_serial_adder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : digit_serial_adder                                           |
// | Description : Multi-cycle WIDTH-bit adder/subtractor processing DIGIT bits |
// |               per clock through a carry register, with start/done          |
// |               handshake and signed-overflow detection.                     |
// |               Optional macro DIGIT_SERIAL_ADDER_SAT_EN: saturate SUM to    |
// |               signed max/min on overflow.                                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module digit_serial_adder
  import digit_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic             SUB,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             CIN,
  output logic             READY,
  output logic [WIDTH-1:0] SUM,
  output logic             COUT,
  output logic             OVF,
  output logic             DONE
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = cnt_width(NDIG);
  localparam logic [CW-1:0] C_LAST = CW'(NDIG - 1);

`ifdef DIGIT_SERIAL_ADDER_SAT_EN
  localparam logic [WIDTH-1:0] C_SAT_MAX = WIDTH'(sat_max(WIDTH));
  localparam logic [WIDTH-1:0] C_SAT_MIN = WIDTH'(sat_min(WIDTH));
`endif

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;

  logic [DIGIT-1:0] w_a_dig;
  logic [DIGIT-1:0] w_b_dig;
  logic [DIGIT-1:0] w_s;
  logic             w_co;
  logic             w_c_msb;
  logic             w_last;
  logic             w_ovf;
  logic [WIDTH-1:0] w_work_next;
  logic [WIDTH-1:0] w_sum_res;

  // Select the digit addressed by the counter from the latched operands
  assign w_a_dig = a_q[int'(cnt_q) * DIGIT +: DIGIT];
  assign w_b_dig = b_q[int'(cnt_q) * DIGIT +: DIGIT];
  assign w_last  = (cnt_q == C_LAST);

  ripple_digit #(
    .DIGIT (DIGIT)
  ) u_slice (
    .a        (w_a_dig),
    .b        (w_b_dig),
    .ci       (carry_q),
    .s        (w_s),
    .co       (w_co),
    .c_msb_in (w_c_msb)
  );

  // Working word with the current digit merged in, plus the result to publish
  always_comb begin
    w_work_next = work_q;
    w_work_next[int'(cnt_q) * DIGIT +: DIGIT] = w_s;
    // On the last digit the slice MSB is the word MSB
    w_ovf = w_c_msb ^ w_co;
`ifdef DIGIT_SERIAL_ADDER_SAT_EN
    if (w_ovf) begin
      w_sum_res = a_q[WIDTH-1] ? C_SAT_MIN : C_SAT_MAX;
    end else begin
      w_sum_res = w_work_next;
    end
`else
    w_sum_res = w_work_next;
`endif
  end

  // Controller and datapath next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    work_d  = work_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (START) begin
          // Subtraction: X + ~Y + ~CIN, i.e. invert B and the incoming carry
          state_d = S_RUN;
          a_d     = X;
          b_d     = Y ^ {WIDTH{SUB}};
          carry_d = CIN ^ SUB;
          cnt_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        work_d  = w_work_next;
        carry_d = w_co;
        if (w_last) begin
          state_d = S_DONE;
          cnt_d   = '0;
          sum_d   = w_sum_res;
          cout_d  = w_co;
          ovf_d   = w_ovf;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    ready_d = (state_d != S_RUN);
    done_d  = (state_d == S_DONE);
  end

  // State and data registers with asynchronous reset
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      work_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      work_q  <= work_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  assign READY = ready_q;
  assign DONE  = done_q;
  assign SUM   = sum_q;
  assign COUT  = cout_q;
  assign OVF   = ovf_q;

endmodule : digit_serial_adder
`default_nettype wire

// File: tb/tb_digit_serial_adder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_digit_serial_adder                                        |
// | Description : Self-checking bench for digit_serial_adder (WIDTH=16,        |
// |               DIGIT=4): directed vector table plus handshake/reset         |
// |               sequences. Honours DIGIT_SERIAL_ADDER_SAT_EN.                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_digit_serial_adder;

  localparam int WIDTH = 16;
  localparam int DIGIT = 4;
  localparam int NDIG  = WIDTH / DIGIT;

  logic             CLK;
  logic             RST_N;
  logic             START;
  logic             SUB;
  logic [WIDTH-1:0] X;
  logic [WIDTH-1:0] Y;
  logic             CIN;
  logic             READY;
  logic [WIDTH-1:0] SUM;
  logic             COUT;
  logic             OVF;
  logic             DONE;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic        sub;
    logic        cin;
    logic [15:0] s;
    logic        co;
    logic        ov;
  } vec_t;

  digit_serial_adder #(
    .WIDTH (WIDTH),
    .DIGIT (DIGIT)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .START (START),
    .SUB   (SUB),
    .X     (X),
    .Y     (Y),
    .CIN   (CIN),
    .READY (READY),
    .SUM   (SUM),
    .COUT  (COUT),
    .OVF   (OVF),
    .DONE  (DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Launch one operation, scramble the inputs after acceptance, check
  // latency, the result and that DONE lasts exactly one cycle.
  task automatic run_op(input vec_t v, input string nm);
    int  lat;
    bit  seen;
    @(negedge CLK);
    X = v.x; Y = v.y; SUB = v.sub; CIN = v.cin; START = 1'b1;
    @(posedge CLK); #1;
    chk({nm, " ready_low"}, 32'(READY), 32'd0);
    @(negedge CLK);
    START = 1'b0; X = ~v.x; Y = v.y ^ 16'h5A5A; SUB = ~v.sub; CIN = ~v.cin;
    lat  = 1;
    seen = 1'b0;
    // One edge has already passed since E0 by the time of the first sample below
    while (!seen && lat < 20) begin
      @(posedge CLK); #1;
      if (DONE) seen = 1'b1;
      else lat++;
    end
    chk({nm, " latency"}, 32'(lat), 32'(NDIG));
    chk({nm, " sum"},  32'(SUM),  32'(v.s));
    chk({nm, " cout"}, 32'(COUT), 32'(v.co));
    chk({nm, " ovf"},  32'(OVF),  32'(v.ov));
    @(posedge CLK); #1;
    chk({nm, " done_one_cycle"}, {30'd0, DONE, READY}, 32'b01);
  endtask

  vec_t tbl[9];

  initial begin
    int done_cnt;
    int t_first;
    int t_second;

    // 0x7FFF+1 and 0x8000-1 and 0x8000+0x8000 overflow; saturation changes SUM
`ifdef DIGIT_SERIAL_ADDER_SAT_EN
    tbl[4] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h7FFF, 1'b0, 1'b1};
    tbl[5] = '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h8000, 1'b1, 1'b1};
    tbl[8] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h8000, 1'b1, 1'b1};
`else
    tbl[4] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[5] = '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1};
    tbl[8] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
`endif
    tbl[0] = '{16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0};
    tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[2] = '{16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0};
    tbl[3] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFD, 1'b0, 1'b0};
    tbl[6] = '{16'h0001, 16'h0001, 1'b0, 1'b1, 16'h0003, 1'b0, 1'b0};
    tbl[7] = '{16'h1234, 16'h1234, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};

    RST_N = 1'b0; START = 1'b0; SUB = 1'b0; X = '0; Y = '0; CIN = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_outputs", {27'd0, READY, DONE, COUT, OVF, 1'b0}, {27'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    chk("reset_sum", 32'(SUM), 32'h0);
    @(negedge CLK); RST_N = 1'b1;

    for (int i = 0; i < 9; i++) begin
      run_op(tbl[i], $sformatf("vec%0d", i));
    end

    // Asynchronous reset mid-cycle clears a nonzero SUM without a clock edge
    run_op(tbl[0], "pre_async");
    @(negedge CLK); #2;
    RST_N = 1'b0;
    #1;
    chk("async_reset_sum", 32'(SUM), 32'h0);
    chk("async_reset_ready", 32'(READY), 32'd1);
    @(negedge CLK); RST_N = 1'b1;

    // START pulsed during RUN is ignored; no second operation follows
    @(negedge CLK);
    X = 16'h1234; Y = 16'h0FFF; SUB = 1'b0; CIN = 1'b0; START = 1'b1;
    @(negedge CLK); START = 1'b0;
    @(negedge CLK); START = 1'b1; X = 16'hAAAA; Y = 16'h1111;
    @(negedge CLK); START = 1'b0;
    done_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge CLK); #1;
      if (DONE) done_cnt++;
    end
    chk("run_start_ignored_dones", 32'(done_cnt), 32'd1);
    chk("run_start_ignored_sum", 32'(SUM), 32'h2233);

    // START held high: back-to-back operations, DONE pulses NDIG+1 apart
    @(negedge CLK);
    X = 16'h1234; Y = 16'h0FFF; SUB = 1'b0; CIN = 1'b0; START = 1'b1;
    done_cnt = 0; t_first = -1; t_second = -1;
    for (int c = 0; c < 20 && done_cnt < 2; c++) begin
      @(posedge CLK); #1;
      if (DONE) begin
        done_cnt++;
        if (done_cnt == 1) t_first = c;
        else t_second = c;
      end
    end
    @(negedge CLK); START = 1'b0;
    chk("b2b_dones", 32'(done_cnt), 32'd2);
    chk("b2b_spacing", 32'(t_second - t_first), 32'(NDIG + 1));
    chk("b2b_sum", 32'(SUM), 32'h2233);

    // Reset while digit 2 is in progress: no DONE, READY after release
    @(negedge CLK);
    X = 16'hFFFF; Y = 16'h0001; START = 1'b1;
    @(posedge CLK); #1;
    @(negedge CLK); START = 1'b0;
    repeat (2) @(posedge CLK);
    #2;
    RST_N = 1'b0;
    #1;
    chk("abort_done", 32'(DONE), 32'd0);
    chk("abort_sum", 32'(SUM), 32'h0);
    @(negedge CLK); RST_N = 1'b1;
    done_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge CLK); #1;
      if (DONE) done_cnt++;
    end
    chk("abort_no_done", 32'(done_cnt), 32'd0);
    chk("abort_ready", 32'(READY), 32'd1);
    chk("abort_cout", 32'(COUT), 32'd0);

    // Block still operational after the aborted run
    run_op(tbl[2], "post_abort");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound so the run always terminates
  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule : tb_digit_serial_adder
`default_nettype wire
